// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART message streamer and its bit timer:
//   - uart_state_t          : streamer FSM state encoding
//   - data_bits             : payload bits per character
//   - bits_per_frame        : start + data + one stop bit
//   - calc_clocks_per_bit() : core clocks per serial bit
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        START = 3'd4,
        DATA  = 3'd5,
        STOP  = 3'd6
    } uart_state_t;

    localparam int data_bits      = 8;
    localparam int bits_per_frame = 1 + data_bits + 1;

    // Integer division: any remainder shows up as baud error, not drift
    // accumulation, because every bit is timed independently from the same count.
    function automatic int calc_clocks_per_bit(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_bit_timer
// Free-running baud tick generator. tick is high for the last clock of each
// clocks_per_bit period; restart forces the period to begin again on the
// next clock so a bit boundary can be aligned to an arbitrary event.
// Ports:
//   clk     in  core clock
//   reset   in  synchronous active-high reset
//   restart in  synchronous restart of the current bit period
//   tick    out registered, high during the final clock of each bit period
// clocks_per_bit must be >= 4.
// ---------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int clocks_per_bit = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int cnt_w = $clog2(clocks_per_bit);
    localparam logic [cnt_w-1:0] last_cnt     = cnt_w'(clocks_per_bit - 1);
    localparam logic [cnt_w-1:0] pre_last_cnt = cnt_w'(clocks_per_bit - 2);

    logic [cnt_w-1:0] count_r;
    logic             tick_r;

    // Bit-period counter; tick is registered one clock ahead so it lines up
    // with the terminal count without a combinational compare on the output.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            count_r <= '0;
            tick_r  <= 1'b0;
        end else begin
            if (count_r == last_cnt) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + cnt_w'(1);
            end
            tick_r <= (count_r == pre_last_cnt);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_msg_streamer.sv
// ---------------------------------------------------------------------------
// uart_msg_streamer
// Streams msg_len bytes from a synchronous-read block RAM out of an 8N1/8N2
// UART transmitter. Optional repeat (loop back to address 0) and
// zero-terminator (0x00 ends the message, not transmitted). cts gates only
// the launch of each byte; a frame in flight always completes.
// Ports:
//   clk         in   core clock
//   reset       in   synchronous active-high reset
//   start       in   one-cycle pulse, accepted only in IDLE
//   cts         in   clear-to-send, checked before each byte launch
//   raddr       out  RAM read address (registered)
//   rdata       in   RAM read data, valid one clock after raddr
//   ser_tx      out  serial line, idle high (registered)
//   busy        out  high from start acceptance until the message ends
//   done        out  one-cycle pulse at end of message
//   byte_strobe out  one-cycle pulse coincident with the first start-bit clock
// ---------------------------------------------------------------------------
module uart_msg_streamer
    import uart_pkg::*;
#(
    parameter int clock_rate   = 24000000,
    parameter int baud_rate    = 115200,
    parameter int addr_width   = 8,
    parameter int msg_len      = 256,
    parameter int stop_bits    = 1,
    parameter int repeat_mode  = 0,
    parameter int stop_on_zero = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  cts,
    output logic [addr_width-1:0] raddr,
    input  logic [7:0]            rdata,
    output logic                  ser_tx,
    output logic                  busy,
    output logic                  done,
    output logic                  byte_strobe
);

    localparam int clocks_per_bit = calc_clocks_per_bit(clock_rate, baud_rate);
    // One extra index bit so msg_len == 2**addr_width is representable.
    localparam int idx_w = addr_width + 1;
    localparam logic [idx_w-1:0] last_index = idx_w'(msg_len - 1);

    // Bit slots within a frame: 0 = start, 1..data_bits = data, then stop slots.
    localparam logic [3:0] last_data_slot = 4'(data_bits);
    localparam logic [3:0] last_slot      = 4'(bits_per_frame - 2 + stop_bits);

    uart_state_t      state_r,  state_s;
    logic [idx_w-1:0] index_r,  index_s;
    logic             busy_r,   busy_s;
    logic             done_r,   done_s;
    logic             strobe_r, strobe_s;
    logic             ser_tx_r, ser_tx_s;
    logic [7:0]       shift_r,  shift_s;
    logic [3:0]       slot_r,   slot_s;
    logic             restart_s;
    logic             tick_s;

    uart_bit_timer #(
        .clocks_per_bit (clocks_per_bit)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // State and datapath registers; reset truncates any frame with the line idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            index_r  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            strobe_r <= 1'b0;
            ser_tx_r <= 1'b1;
            shift_r  <= 8'h00;
            slot_r   <= 4'd0;
        end else begin
            state_r  <= state_s;
            index_r  <= index_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            strobe_r <= strobe_s;
            ser_tx_r <= ser_tx_s;
            shift_r  <= shift_s;
            slot_r   <= slot_s;
        end
    end

    // Next-state and next-output logic for the streamer FSM.
    always_comb begin
        state_s   = state_r;
        index_s   = index_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        strobe_s  = 1'b0;
        shift_s   = shift_r;
        slot_s    = slot_r;
        restart_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = FETCH;
                    busy_s  = 1'b1;
                    index_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end

            FETCH: begin
                state_s = WAIT;
            end

            WAIT: begin
                shift_s = rdata;
                state_s = CHECK;
                // A terminator is flagged here so done lands in the CHECK cycle.
                if ((stop_on_zero != 0) && (rdata == 8'h00)) begin
                    done_s = 1'b1;
                    if (repeat_mode != 0) begin
                        busy_s = busy_r;
                    end else begin
                        busy_s = 1'b0;
                    end
                end else begin
                    done_s = 1'b0;
                end
            end

            CHECK: begin
                if ((stop_on_zero != 0) && (shift_r == 8'h00)) begin
                    if (repeat_mode != 0) begin
                        index_s = '0;
                        state_s = FETCH;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (cts) begin
                    strobe_s  = 1'b1;
                    restart_s = 1'b1;
                    slot_s    = 4'd0;
                    state_s   = START;
                end else begin
                    state_s = CHECK;
                end
            end

            START: begin
                if (tick_s) begin
                    slot_s  = slot_r + 4'd1;
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end

            DATA: begin
                if (tick_s) begin
                    slot_s = slot_r + 4'd1;
                    if (slot_r == last_data_slot) begin
                        state_s = STOP;
                    end else begin
                        shift_s = {1'b1, shift_r[7:1]};
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end

            STOP: begin
                if (tick_s) begin
                    if (slot_r == last_slot) begin
                        if (index_r == last_index) begin
                            done_s = 1'b1;
                            if (repeat_mode != 0) begin
                                index_s = '0;
                                state_s = FETCH;
                            end else begin
                                busy_s  = 1'b0;
                                state_s = IDLE;
                            end
                        end else begin
                            index_s = index_r + idx_w'(1);
                            state_s = FETCH;
                        end
                    end else begin
                        slot_s  = slot_r + 4'd1;
                        state_s = STOP;
                    end
                end else begin
                    state_s = STOP;
                end
            end

            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Line level for the coming cycle, derived from the next state so ser_tx is a flop.
    always_comb begin
        ser_tx_s = 1'b1;
        case (state_s)
            START:   ser_tx_s = 1'b0;
            DATA:    ser_tx_s = shift_s[0];
            default: ser_tx_s = 1'b1;
        endcase
    end

    assign raddr       = index_r[addr_width-1:0];
    assign ser_tx      = ser_tx_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign byte_strobe = strobe_r;

endmodule

// File: tb/tb_uart_msg_streamer.sv
module tb_uart_msg_streamer;

    localparam int n_dut = 5;
    // 0: base (12 clk/bit, 3 bytes)  1: stop_on_zero  2: repeat, 2 bytes
    // 3: two stop bits, 2 bytes      4: 256 bytes at 4 clk/bit

    logic       clk = 1'b0;
    logic       reset;
    logic       start_v [n_dut];
    logic       cts_v   [n_dut];
    logic [7:0] raddr_v [n_dut];
    logic [7:0] rdata_v [n_dut];
    logic       ser_v   [n_dut];
    logic       busy_v  [n_dut];
    logic       done_v  [n_dut];
    logic       strb_v  [n_dut];
    logic [7:0] mem [n_dut][256];
    int         cpb_v [n_dut];

    int checks = 0;
    int errors = 0;
    int strobe_q[$];
    int addr_q[$];
    int done_q[$];
    int busy_low;
    int bit0_bad;

    typedef struct {
        int   inst;
        int   cyc;
        logic ser;
        logic busy;
        logic strb;
        logic done;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int k = 0; k < n_dut; k++) rdata_v[k] <= mem[k][raddr_v[k]];
    end

    uart_msg_streamer #(.clock_rate(12), .baud_rate(1), .addr_width(8), .msg_len(3),
        .stop_bits(1), .repeat_mode(0), .stop_on_zero(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .cts(cts_v[0]), .raddr(raddr_v[0]),
        .rdata(rdata_v[0]), .ser_tx(ser_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .byte_strobe(strb_v[0]));

    uart_msg_streamer #(.clock_rate(12), .baud_rate(1), .addr_width(8), .msg_len(3),
        .stop_bits(1), .repeat_mode(0), .stop_on_zero(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .cts(cts_v[1]), .raddr(raddr_v[1]),
        .rdata(rdata_v[1]), .ser_tx(ser_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .byte_strobe(strb_v[1]));

    uart_msg_streamer #(.clock_rate(12), .baud_rate(1), .addr_width(8), .msg_len(2),
        .stop_bits(1), .repeat_mode(1), .stop_on_zero(0)) dut_r (
        .clk(clk), .reset(reset), .start(start_v[2]), .cts(cts_v[2]), .raddr(raddr_v[2]),
        .rdata(rdata_v[2]), .ser_tx(ser_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .byte_strobe(strb_v[2]));

    uart_msg_streamer #(.clock_rate(12), .baud_rate(1), .addr_width(8), .msg_len(2),
        .stop_bits(2), .repeat_mode(0), .stop_on_zero(0)) dut_s2 (
        .clk(clk), .reset(reset), .start(start_v[3]), .cts(cts_v[3]), .raddr(raddr_v[3]),
        .rdata(rdata_v[3]), .ser_tx(ser_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .byte_strobe(strb_v[3]));

    uart_msg_streamer #(.clock_rate(4), .baud_rate(1), .addr_width(8), .msg_len(256),
        .stop_bits(1), .repeat_mode(0), .stop_on_zero(0)) dut_f (
        .clk(clk), .reset(reset), .start(start_v[4]), .cts(cts_v[4]), .raddr(raddr_v[4]),
        .rdata(rdata_v[4]), .ser_tx(ser_v[4]), .busy(busy_v[4]), .done(done_v[4]),
        .byte_strobe(strb_v[4]));

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic add(input int i, input int c, input logic s, input logic b,
                       input logic t, input logic d);
        vec_t v;
        v.inst = i; v.cyc = c; v.ser = s; v.busy = b; v.strb = t; v.done = d;
        tbl.push_back(v);
    endtask

    // Pulse start on DUT k, then observe ncyc cycles (cycle 0 = first cycle after
    // start is accepted), applying table vectors and recording events.
    task automatic run_msg(input int k, input int ncyc, input int start_at);
        int   pend_cyc;
        logic pend_bit;
        strobe_q.delete(); addr_q.delete(); done_q.delete();
        busy_low = 0; bit0_bad = 0; pend_cyc = -1; pend_bit = 1'b0;
        @(posedge clk); #1 start_v[k] = 1'b1;
        @(posedge clk); #1 start_v[k] = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (n == start_at) start_v[k] = 1'b1;
            else if (n == start_at + 1) start_v[k] = 1'b0;
            if (strb_v[k] === 1'b1) begin
                strobe_q.push_back(n);
                addr_q.push_back(int'(raddr_v[k]));
                pend_cyc = n + cpb_v[k];
                pend_bit = mem[k][raddr_v[k]][0];
            end
            if (n == pend_cyc && ser_v[k] !== pend_bit) bit0_bad++;
            if (done_v[k] === 1'b1) done_q.push_back(n);
            if (busy_v[k] !== 1'b1) busy_low++;
            foreach (tbl[i]) begin
                if (tbl[i].inst == k && tbl[i].cyc == n) begin
                    check($sformatf("ser_tx[%0d]@%0d", k, n), 32'(ser_v[k]), 32'(tbl[i].ser));
                    check($sformatf("busy[%0d]@%0d", k, n), 32'(busy_v[k]), 32'(tbl[i].busy));
                    check($sformatf("strobe[%0d]@%0d", k, n), 32'(strb_v[k]), 32'(tbl[i].strb));
                    check($sformatf("done[%0d]@%0d", k, n), 32'(done_v[k]), 32'(tbl[i].done));
                end
            end
        end
    endtask

    initial begin
        int bad;
        int nst;
        int found;

        // RAM images
        for (int k = 0; k < n_dut; k++)
            for (int a = 0; a < 256; a++) mem[k][a] = 8'h00;
        for (int k = 0; k < 4; k++) begin
            mem[k][0] = 8'h55; mem[k][1] = 8'hA3; mem[k][2] = 8'h00;
        end
        for (int a = 0; a < 256; a++) mem[4][a] = 8'(a) ^ 8'h5A;
        cpb_v[0] = 12; cpb_v[1] = 12; cpb_v[2] = 12; cpb_v[3] = 12; cpb_v[4] = 4;

        // Base config, 0x55 / 0xA3 / 0x00, 12 clk/bit, strobes at 3, 126, 249
        add(0,   0, 1, 1, 0, 0); add(0,   2, 1, 1, 0, 0); add(0,   3, 0, 1, 1, 0);
        add(0,  14, 0, 1, 0, 0); add(0,  15, 1, 1, 0, 0); add(0,  26, 1, 1, 0, 0);
        add(0,  27, 0, 1, 0, 0); add(0,  39, 1, 1, 0, 0); add(0,  51, 0, 1, 0, 0);
        add(0,  63, 1, 1, 0, 0); add(0,  75, 0, 1, 0, 0); add(0,  87, 1, 1, 0, 0);
        add(0,  99, 0, 1, 0, 0); add(0, 110, 0, 1, 0, 0); add(0, 111, 1, 1, 0, 0);
        add(0, 122, 1, 1, 0, 0); add(0, 125, 1, 1, 0, 0); add(0, 126, 0, 1, 1, 0);
        add(0, 138, 1, 1, 0, 0); add(0, 150, 1, 1, 0, 0); add(0, 162, 0, 1, 0, 0);
        add(0, 174, 0, 1, 0, 0); add(0, 186, 0, 1, 0, 0); add(0, 198, 1, 1, 0, 0);
        add(0, 210, 0, 1, 0, 0); add(0, 222, 1, 1, 0, 0); add(0, 234, 1, 1, 0, 0);
        add(0, 249, 0, 1, 1, 0); add(0, 261, 0, 1, 0, 0); add(0, 345, 0, 1, 0, 0);
        add(0, 357, 1, 1, 0, 0); add(0, 368, 1, 1, 0, 0); add(0, 369, 1, 0, 0, 1);
        add(0, 370, 1, 0, 0, 0);
        // stop_on_zero: done in CHECK of byte 2 (cycle 248)
        add(1, 247, 1, 1, 0, 0); add(1, 248, 1, 0, 0, 1); add(1, 249, 1, 0, 0, 0);
        // repeat mode
        add(2, 246, 1, 1, 0, 1); add(2, 249, 0, 1, 1, 0); add(2, 492, 1, 1, 0, 1);
        add(2, 549, 0, 1, 0, 0);
        // two stop bits
        add(3,   3, 0, 1, 1, 0); add(3, 111, 1, 1, 0, 0); add(3, 134, 1, 1, 0, 0);
        add(3, 135, 1, 1, 0, 0); add(3, 138, 0, 1, 1, 0); add(3, 270, 1, 0, 0, 1);

        reset = 1'b1;
        for (int k = 0; k < n_dut; k++) begin
            start_v[k] = 1'b0;
            cts_v[k]   = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < n_dut; k++) begin
            check($sformatf("reset_ser_tx[%0d]", k), 32'(ser_v[k]), 32'd1);
            check($sformatf("reset_busy[%0d]", k), 32'(busy_v[k]), 32'd0);
            check($sformatf("reset_done[%0d]", k), 32'(done_v[k]), 32'd0);
            check($sformatf("reset_strobe[%0d]", k), 32'(strb_v[k]), 32'd0);
            check($sformatf("reset_raddr[%0d]", k), 32'(raddr_v[k]), 32'd0);
        end
        @(posedge clk); #1 reset = 1'b0;

        // Base message
        run_msg(0, 400, -1);
        check("base_strobes", strobe_q.size(), 3);
        check("base_dones", done_q.size(), 1);

        // Zero terminator
        run_msg(1, 400, -1);
        check("soz_strobes", strobe_q.size(), 2);
        check("soz_dones", done_q.size(), 1);
        check("soz_done_cycle", (done_q.size() > 0) ? done_q[0] : -1, 248);

        // cts held low before start, released 50 cycles later
        cts_v[0] = 1'b0;
        @(posedge clk); #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        bad = 0; nst = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ser_v[0] !== 1'b1) bad++;
            if (strb_v[0] === 1'b1) nst++;
        end
        check("cts_line_idle", bad, 0);
        check("cts_no_strobe", nst, 0);
        @(posedge clk); #1 cts_v[0] = 1'b1;
        @(negedge clk);
        check("cts_rise_cycle_strobe", 32'(strb_v[0]), 32'd0);
        @(negedge clk);
        check("cts_next_cycle_strobe", 32'(strb_v[0]), 32'd1);
        check("cts_next_cycle_ser_tx", 32'(ser_v[0]), 32'd0);
        found = 0;
        for (int n = 0; n < 400 && found == 0; n++) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) found = 1;
        end
        check("cts_done_seen", found, 1);

        // Two stop bits; a start pulse in FETCH of byte 1 must be ignored
        run_msg(3, 300, 135);
        check("s2_strobes", strobe_q.size(), 2);
        check("s2_spacing", (strobe_q.size() >= 2) ? strobe_q[1] - strobe_q[0] : -1, 135);
        check("s2_addr_byte1", (addr_q.size() >= 2) ? addr_q[1] : -1, 1);
        check("s2_dones", done_q.size(), 1);

        // Repeat mode, then reset mid-DATA
        run_msg(2, 550, -1);
        check("rep_strobes", strobe_q.size(), 5);
        for (int i = 0; i < 4; i++)
            check($sformatf("rep_raddr_%0d", i), (addr_q.size() > i) ? addr_q[i] : -1, i % 2);
        check("rep_dones", done_q.size(), 2);
        check("rep_done0", (done_q.size() > 0) ? done_q[0] : -1, 246);
        check("rep_done1", (done_q.size() > 1) ? done_q[1] : -1, 492);
        check("rep_busy_low_cycles", busy_low, 0);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_ser_tx", 32'(ser_v[2]), 32'd1);
        check("midreset_busy", 32'(busy_v[2]), 32'd0);
        check("midreset_done", 32'(done_v[2]), 32'd0);
        check("midreset_raddr", 32'(raddr_v[2]), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Full 256-byte message
        run_msg(4, 12000, -1);
        check("full_strobes", strobe_q.size(), 256);
        bad = 0;
        foreach (addr_q[i]) if (addr_q[i] != i) bad++;
        check("full_addr_order", bad, 0);
        check("full_last_addr", (addr_q.size() > 0) ? addr_q[addr_q.size()-1] : -1, 255);
        check("full_dones", done_q.size(), 1);
        check("full_done_after_last",
              (done_q.size() > 0 && strobe_q.size() > 0) ? done_q[0] - strobe_q[strobe_q.size()-1] : -1,
              40);
        check("full_bit0_values", bit0_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
